pipe_hazard_ctrl: RTL and testbench

Stall and bubble controller for the 5-stage MIPS pipeline. It decodes the instructions held in the IF/ID, ID/EX and EX/MEM pipeline registers and applies Tuse/Tnew hazard rules. It also sequences the multi-cycle multiply/divide unit with a busy counter. Its outputs freeze the PC and the IF/ID register and inject a NOP bubble into ID/EX whenever a hazard cannot be resolved by forwarding.

---
 rtl/pipe_hazard_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble controller for the 5-stage MIPS pipeline.
// Applies Tuse/Tnew rules to the IF/ID, ID/EX and EX/MEM instructions. It also
// tracks the multi-cycle multiply/divide unit with a busy counter.
module pipe_hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] D_instr,
   input  logic [31:0] E_instr,
   input  logic [4:0]  E_WA,
   input  logic [31:0] M_instr,
   input  logic [4:0]  M_WA,
   output logic        PC_en,
   output logic        IFID_en,
   output logic        IDEX_clr,
   output logic        md_start,
   output logic [1:0]  md_op,
   output logic        md_busy
);

   localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_MFHI    = 6'h10;
   localparam logic [5:0] FN_MTHI    = 6'h11;
   localparam logic [5:0] FN_MFLO    = 6'h12;
   localparam logic [5:0] FN_MTLO    = 6'h13;
   localparam logic [5:0] FN_MULT    = 6'h18;
   localparam logic [5:0] FN_MULTU   = 6'h19;
   localparam logic [5:0] FN_DIV     = 6'h1A;
   localparam logic [5:0] FN_DIVU    = 6'h1B;
   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_SUBU    = 6'h23;

   // Tuse of 3 marks an unused source field: it can never be below any Tnew.
   localparam logic [1:0] TUSE_NONE  = 2'd3;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   md_state_t       state_q, state_d;
   logic [CW-1:0]   count_q, count_d;

   logic [1:0]      d_tuse_rs, d_tuse_rt;
   logic            d_md_group;
   logic [1:0]      e_tnew;
   logic            e_is_md;
   logic [1:0]      m_tnew;

   logic [4:0]      src_addr   [2];
   logic [1:0]      src_tuse   [2];
   logic [1:0]      src_hazard;
   logic            data_stall;
   logic            md_stall;
   logic            stall;

   // Decode the D-stage instruction into per-field Tuse and the MD-group flag.
   always_comb begin
      d_tuse_rs  = TUSE_NONE;
      d_tuse_rt  = TUSE_NONE;
      d_md_group = 1'b0;
      if (D_instr[31:26] == OP_SPECIAL) begin
         case (D_instr[5:0])
            FN_ADDU, FN_SUBU: begin
               d_tuse_rs = 2'd1;
               d_tuse_rt = 2'd1;
            end
            FN_JR: d_tuse_rs = 2'd0;
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
               d_tuse_rs  = 2'd1;
               d_tuse_rt  = 2'd1;
               d_md_group = 1'b1;
            end
            FN_MFHI, FN_MFLO: d_md_group = 1'b1;
            FN_MTHI, FN_MTLO: begin
               d_tuse_rs  = 2'd1;
               d_md_group = 1'b1;
            end
            default: ;
         endcase
      end else begin
         case (D_instr[31:26])
            OP_ORI, OP_LUI, OP_LW: d_tuse_rs = 2'd1;
            OP_SW: begin
               d_tuse_rs = 2'd1;
               d_tuse_rt = 2'd2;
            end
            OP_BEQ: begin
               d_tuse_rs = 2'd0;
               d_tuse_rt = 2'd0;
            end
            default: ;
         endcase
      end
   end

   // Decode Tnew for the E- and M-stage instructions and spot an MD issue in E.
   always_comb begin
      e_tnew  = 2'd0;
      e_is_md = 1'b0;
      m_tnew  = 2'd0;
      if (E_instr[31:26] == OP_SPECIAL) begin
         case (E_instr[5:0])
            FN_ADDU, FN_SUBU, FN_MFHI, FN_MFLO: e_tnew = 2'd1;
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: e_is_md = 1'b1;
            default: ;
         endcase
      end else begin
         case (E_instr[31:26])
            OP_ORI, OP_LUI: e_tnew = 2'd1;
            OP_LW:          e_tnew = 2'd2;
            default: ;
         endcase
      end
      if (M_instr[31:26] == OP_LW) begin
         m_tnew = 2'd1;
      end
   end

   assign src_addr[0] = D_instr[25:21];
   assign src_addr[1] = D_instr[20:16];
   assign src_tuse[0] = d_tuse_rs;
   assign src_tuse[1] = d_tuse_rt;

   // One hazard comparator per source field (rs, rt); $0 never matches.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         assign src_hazard[gi] =
            ((src_addr[gi] == E_WA) && (E_WA != 5'd0) && (src_tuse[gi] < e_tnew)) ||
            ((src_addr[gi] == M_WA) && (M_WA != 5'd0) && (src_tuse[gi] < m_tnew));
      end
   endgenerate

   assign data_stall = |src_hazard;
   assign md_stall   = d_md_group && (e_is_md || (state_q == MD_BUSY));
   // Reset forces the pipeline to run free and suppresses any MD start.
   assign stall      = !reset && (data_stall || md_stall);

   assign PC_en    = !stall;
   assign IFID_en  = !stall;
   assign IDEX_clr = stall;
   assign md_start = !reset && e_is_md;
   assign md_op    = E_instr[1:0];
   assign md_busy  = (state_q == MD_BUSY);

   // Next busy count: load on an MD issue, otherwise count down to zero.
   always_comb begin
      count_d = count_q;
      if (e_is_md) begin
         count_d = E_instr[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (count_q != '0) begin
         count_d = count_q - CW'(1);
      end
      state_d = (count_d != '0) ? MD_BUSY : MD_IDLE;
   end

   // MD unit state and counter; reset clears both even mid-operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MD_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Instruction bits that play no part in hazard detection.
   logic unused_bits;
   assign unused_bits = ^{D_instr[15:6], E_instr[25:6], M_instr[25:0]};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plus random stimulus against a rule-level
// reference model; expected outputs are queued by the driver and checked by
// an independent monitor on the falling edge.
module tb_pipe_hazard_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;
   localparam int UNUSED = 99;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] D_instr, E_instr, M_instr;
   logic [4:0]  E_WA, M_WA;
   logic        PC_en, IFID_en, IDEX_clr, md_start, md_busy;
   logic [1:0]  md_op;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset),
      .D_instr(D_instr), .E_instr(E_instr), .E_WA(E_WA),
      .M_instr(M_instr), .M_WA(M_WA),
      .PC_en(PC_en), .IFID_en(IFID_en), .IDEX_clr(IDEX_clr),
      .md_start(md_start), .md_op(md_op), .md_busy(md_busy)
   );

   typedef struct packed {
      logic       pc_en;
      logic       ifid_en;
      logic       idex_clr;
      logic       md_start;
      logic [1:0] md_op;
      logic       md_busy;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle = 0;
   int   busy_last = -1;   // last cycle index in which the MD unit is busy
   bit   stim_done = 0;

   // ---------------- encoders ----------------
   function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt);
      return {op, rs, rt, 16'h0004};
   endfunction

   // ---------------- reference rules ----------------
   function automatic int tuse_rs(input logic [31:0] i);
      if (i[31:26] == 6'h00) begin
         if (i[5:0] == 6'h21 || i[5:0] == 6'h23) return 1;
         if (i[5:0] >= 6'h18 && i[5:0] <= 6'h1B) return 1;
         if (i[5:0] == 6'h11 || i[5:0] == 6'h13) return 1;
         if (i[5:0] == 6'h08) return 0;
         return UNUSED;
      end
      if (i[31:26] == 6'h0D || i[31:26] == 6'h0F || i[31:26] == 6'h23 || i[31:26] == 6'h2B)
         return 1;
      if (i[31:26] == 6'h04) return 0;
      return UNUSED;
   endfunction

   function automatic int tuse_rt(input logic [31:0] i);
      if (i[31:26] == 6'h00) begin
         if (i[5:0] == 6'h21 || i[5:0] == 6'h23) return 1;
         if (i[5:0] >= 6'h18 && i[5:0] <= 6'h1B) return 1;
         return UNUSED;
      end
      if (i[31:26] == 6'h04) return 0;
      if (i[31:26] == 6'h2B) return 2;
      return UNUSED;
   endfunction

   function automatic int tnew_e(input logic [31:0] i);
      if (i[31:26] == 6'h00)
         return (i[5:0] == 6'h21 || i[5:0] == 6'h23 || i[5:0] == 6'h10 || i[5:0] == 6'h12) ? 1 : 0;
      if (i[31:26] == 6'h0D || i[31:26] == 6'h0F) return 1;
      if (i[31:26] == 6'h23) return 2;
      return 0;
   endfunction

   function automatic int tnew_m(input logic [31:0] i);
      return (i[31:26] == 6'h23) ? 1 : 0;
   endfunction

   function automatic bit is_md(input logic [31:0] i);
      return (i[31:26] == 6'h00) && (i[5:0] >= 6'h18) && (i[5:0] <= 6'h1B);
   endfunction

   function automatic bit uses_hilo(input logic [31:0] i);
      return is_md(i) || ((i[31:26] == 6'h00) && (i[5:0] >= 6'h10) && (i[5:0] <= 6'h13));
   endfunction

   function automatic bit reg_hazard(input int r, input int tu, input logic [31:0] e,
                                     input int ewa, input logic [31:0] m, input int mwa);
      if (tu == UNUSED || r == 0) return 0;
      return (r == ewa && tu < tnew_e(e)) || (r == mwa && tu < tnew_m(m));
   endfunction

   function automatic exp_t model(input logic rst, input logic [31:0] d, input logic [31:0] e,
                                  input logic [4:0] ewa, input logic [31:0] m,
                                  input logic [4:0] mwa, input bit busy);
      exp_t x;
      bit   data_st, md_st, st;
      data_st = reg_hazard(int'(d[25:21]), tuse_rs(d), e, int'(ewa), m, int'(mwa)) ||
                reg_hazard(int'(d[20:16]), tuse_rt(d), e, int'(ewa), m, int'(mwa));
      md_st   = uses_hilo(d) && (is_md(e) || busy);
      st      = !rst && (data_st || md_st);
      x.pc_en    = !st;
      x.ifid_en  = !st;
      x.idex_clr = st;
      x.md_start = !rst && is_md(e);
      x.md_op    = e[1:0];
      x.md_busy  = busy;
      return x;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [4:0] a, b, c;
      a = 5'($urandom_range(0, 3));
      b = 5'($urandom_range(0, 3));
      c = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 13))
         0:  return 32'h0;
         1:  return rtype(6'h21, a, b, c);
         2:  return rtype(6'h23, a, b, c);
         3:  return itype(6'h0D, a, b);
         4:  return itype(6'h0F, a, b);
         5:  return itype(6'h23, a, b);
         6:  return itype(6'h2B, a, b);
         7:  return itype(6'h04, a, b);
         8:  return {6'h03, 26'h10};
         9:  return rtype(6'h08, a, 5'd0, 5'd0);
         10: return rtype(6'h18 + 6'($urandom_range(0, 3)), a, b, 5'd0);
         11: return rtype($urandom_range(0, 1) ? 6'h10 : 6'h12, 5'd0, 5'd0, c);
         default: return rtype($urandom_range(0, 1) ? 6'h11 : 6'h13, a, 5'd0, 5'd0);
      endcase
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input logic rst, input logic [31:0] d, input logic [31:0] e,
                        input logic [4:0] ewa, input logic [31:0] m, input logic [4:0] mwa);
      @(posedge clk);
      cycle++;
      // Effect of this edge on the MD unit, from the values held before it.
      if (reset)
         busy_last = cycle - 1;
      else if (is_md(E_instr))
         busy_last = cycle + (E_instr[1] ? DIV_N : MULT_N) - 1;
      #1;
      reset   = rst;
      D_instr = d;
      E_instr = e;
      E_WA    = ewa;
      M_instr = m;
      M_WA    = mwa;
      exp_q.push_back(model(rst, d, e, ewa, m, mwa, cycle <= busy_last));
   endtask

   task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s cycle %0d got %b expected %b", name, cycle, got, want);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("PC_en",    {1'b0, PC_en},    {1'b0, x.pc_en});
            check("IFID_en",  {1'b0, IFID_en},  {1'b0, x.ifid_en});
            check("IDEX_clr", {1'b0, IDEX_clr}, {1'b0, x.idex_clr});
            check("md_start", {1'b0, md_start}, {1'b0, x.md_start});
            check("md_busy",  {1'b0, md_busy},  {1'b0, x.md_busy});
            if (x.md_start) check("md_op", md_op, x.md_op);
            $display("cycle %0d rst=%b D=%h E=%h ewa=%0d M=%h mwa=%0d pc_en=%b clr=%b start=%b busy=%b",
                     cycle, reset, D_instr, E_instr, E_WA, M_instr, M_WA,
                     PC_en, IDEX_clr, md_start, md_busy);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] lw1, addu213, addu4, beq4, lw5, sw_rt5, sw_rs5, mult12, mflo3, divu12;
      logic [31:0] addu_to0, addu_from0, e_r, d_r, m_r;
      reset   = 1'b1;
      D_instr = '0; E_instr = '0; M_instr = '0;
      E_WA    = '0; M_WA    = '0;

      lw1        = itype(6'h23, 5'd0, 5'd1);
      addu213    = rtype(6'h21, 5'd1, 5'd3, 5'd2);
      addu4      = rtype(6'h21, 5'd1, 5'd2, 5'd4);
      beq4       = itype(6'h04, 5'd4, 5'd0);
      lw5        = itype(6'h23, 5'd0, 5'd5);
      sw_rt5     = itype(6'h2B, 5'd6, 5'd5);
      sw_rs5     = itype(6'h2B, 5'd5, 5'd6);
      mult12     = rtype(6'h18, 5'd1, 5'd2, 5'd0);
      mflo3      = rtype(6'h12, 5'd0, 5'd0, 5'd3);
      divu12     = rtype(6'h1B, 5'd1, 5'd2, 5'd0);
      addu_to0   = rtype(6'h21, 5'd1, 5'd2, 5'd0);
      addu_from0 = rtype(6'h21, 5'd0, 5'd0, 5'd1);

      drive(1, 0, 0, 0, 0, 0);
      drive(1, addu213, lw1, 1, 0, 0);            // outputs held free during reset
      // load-use: one stall, then forwarding from M suffices
      drive(0, addu213, lw1, 1, 0, 0);
      drive(0, addu213, 0, 0, lw1, 1);
      drive(0, 0, addu213, 2, 0, 0);
      // branch on ALU result in E, then in M
      drive(0, beq4, addu4, 4, 0, 0);
      drive(0, beq4, 0, 0, addu4, 4);
      // store data (late use) vs store base
      drive(0, sw_rt5, lw5, 5, 0, 0);
      drive(0, sw_rs5, lw5, 5, 0, 0);
      // mult then mflo: 1 start cycle + 5 busy cycles of stall
      drive(0, mflo3, mult12, 0, 0, 0);
      repeat (7) drive(0, mflo3, 0, 0, mult12, 0);
      // divu interrupted by reset on the 3rd busy cycle
      drive(0, mflo3, divu12, 0, 0, 0);
      drive(0, mflo3, 0, 0, divu12, 0);
      drive(0, mflo3, 0, 0, 0, 0);
      drive(1, mflo3, 0, 0, 0, 0);
      drive(0, mflo3, 0, 0, 0, 0);
      drive(0, mflo3, 0, 0, 0, 0);
      // $0 and NOP never stall
      drive(0, addu_from0, addu_to0, 0, 0, 0);
      drive(0, 0, lw1, 1, lw1, 1);

      for (int n = 0; n < 800; n++) begin
         d_r = rand_instr();
         e_r = rand_instr();
         m_r = rand_instr();
         if (is_md(e_r) && ($urandom_range(0, 2) != 0)) e_r = '0;
         drive(($urandom_range(0, 49) == 0), d_r, e_r, 5'($urandom_range(0, 3)),
               m_r, 5'($urandom_range(0, 3)));
      end
      stim_done = 1;
   end

   // ---------------- end of run ----------------
   initial begin
      wait (stim_done);
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
